// File: rtl/ram_scan_reader.sv
// Read-side scan sequencer for the 32x3 lab RAM.
// Steps rd_addr once per display period and holds the captured word for the HEX decoders.
module ram_scan_reader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 3,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              tick,
  output logic              wrap
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int LAT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [LAT_W-1:0]    r_lat, w_lat;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr;
  logic [ADDR_W-1:0]   r_disp_addr, w_disp_addr;
  logic [DATA_W-1:0]   r_disp_data, w_disp_data;
  logic                r_valid, w_valid;
  logic                r_tick, w_tick;
  logic                r_wrap, w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_rd_addr   <= '0;
      r_disp_addr <= '0;
      r_disp_data <= '0;
      r_valid     <= 1'b0;
      r_tick      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_lat       <= w_lat;
      r_rd_addr   <= w_rd_addr;
      r_disp_addr <= w_disp_addr;
      r_disp_data <= w_disp_data;
      r_valid     <= w_valid;
      r_tick      <= w_tick;
      r_wrap      <= w_wrap;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_lat       = r_lat;
    w_rd_addr   = r_rd_addr;
    w_disp_addr = r_disp_addr;
    w_disp_data = r_disp_data;
    w_valid     = r_valid;
    w_tick      = 1'b0;
    w_wrap      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state = FETCH;
          w_lat   = '0;
        end
      end
      FETCH: begin
        // one cycle for the RAM to sample rd_addr, then RD_LATENCY to q
        if (r_lat == LAT_LAST) begin
          w_disp_data = rd_data;
          w_disp_addr = r_rd_addr;
          w_valid     = 1'b1;
          w_cnt       = '0;
          w_state     = SHOW;
        end else begin
          w_lat = r_lat + 1'b1;
        end
      end
      SHOW: begin
        w_disp_data = rd_data;
        if (enable) begin
          if (r_cnt == CNT_LAST) begin
            w_tick    = 1'b1;
            w_wrap    = &r_rd_addr;
            w_cnt     = '0;
            w_lat     = '0;
            w_rd_addr = r_rd_addr + 1'b1;
            w_state   = FETCH;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign rd_addr    = r_rd_addr;
  assign disp_addr  = r_disp_addr;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_valid;
  assign tick       = r_tick;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader with a 32x3 RAM model and a capture scoreboard.
// TICK_CYCLES=4, RD_LATENCY=1.
module tb_ram_scan_reader;

  logic       clk = 1'b0;
  logic       reset, enable, we;
  logic [4:0] rd_addr, disp_addr, waddr;
  logic [2:0] rd_data, disp_data, wdata;
  logic       disp_valid, tick, wrap;

  logic [2:0] mem   [32];
  logic [2:0] model [32];
  logic [7:0] sb_q  [$];

  int n_tot = 0;
  int n_bad = 0;
  int n;

  ram_scan_reader #(
    .ADDR_W(5), .DATA_W(3), .TICK_CYCLES(4), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] d);
    we = 1'b1; waddr = a; wdata = d;
    model[a] = d;
    step(1);
    we = 1'b0;
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    while (1) begin
      step(1);
      cnt++;
      if (tick === 1'b1) break;
      if (cnt >= 40) begin
        chk("tick_timeout", {31'd0, tick}, 32'd1);
        break;
      end
    end
  endtask

  task automatic push(input logic [4:0] a);
    sb_q.push_back({a, model[a]});
  endtask

  logic       prev_v;
  logic [4:0] prev_a;
  logic [7:0] e;
  always @(negedge clk) begin
    if (disp_valid === 1'b1 &&
        (prev_v !== 1'b1 || disp_addr !== prev_a)) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", disp_addr, e[7:3]);
        chk("sb_data", disp_data, e[2:0]);
      end
    end
    prev_v = disp_valid;
    prev_a = disp_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; we = 1'b0;
    waddr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) begin
      case (i)
        0:       model[i] = 3'd7;
        1:       model[i] = 3'd2;
        2:       model[i] = 3'd4;
        31:      model[i] = 3'd5;
        default: model[i] = 3'((i * 3) % 8);
      endcase
    end
    for (int i = 0; i < 32; i++) wr(5'(i), model[i]);
    step(1);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_disp_addr", disp_addr, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);

    // first fetch
    reset = 1'b0; enable = 1'b1;
    push(0); push(1); push(2);
    step(1); chk("ff_valid1", disp_valid, 0);
    step(1); chk("ff_valid2", disp_valid, 0);
    step(1); chk("ff_valid3", disp_valid, 1);
    chk("ff_addr", disp_addr, 0);
    chk("ff_data", disp_data, 7);

    // periodic stepping
    step(3); chk("pre_tick", tick, 0);
    step(1); chk("tick1", tick, 1);
    chk("tick1_rd", rd_addr, 1);
    chk("tick1_wrap", wrap, 0);
    step(1); chk("tick1_pulse", tick, 0);
    step(1); chk("w1_addr", disp_addr, 1);
    chk("w1_data", disp_data, 2);
    wait_tick(n); chk("period_a", n, 4);
    chk("tick2_rd", rd_addr, 2);
    step(2); chk("w2_addr", disp_addr, 2);
    chk("w2_data", disp_data, 4);

    // freeze at counter 2, with a live write to the shown word
    step(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("frz_tick", tick, 0);
      chk("frz_rd", rd_addr, 2);
      chk("frz_disp", disp_addr, 2);
      if (i == 1) begin
        we = 1'b1; waddr = 5'd2; wdata = 3'd6;
        model[2] = 3'd6;
      end
      if (i == 2) we = 1'b0;
      if (i == 4) chk("live_data", disp_data, 6);
    end
    enable = 1'b1;
    for (int a = 3; a < 32; a++) push(5'(a));
    push(0);
    step(1); chk("unfrz_tick0", tick, 0);
    step(1); chk("unfrz_tick1", tick, 1);
    chk("unfrz_rd", rd_addr, 3);

    // run to the top of the address space
    for (int a = 4; a < 32; a++) begin
      wait_tick(n);
      chk("period", n, 6);
      chk("rd_step", rd_addr, a);
      chk("wrap_lo", wrap, 0);
    end
    step(2);
    chk("w31_addr", disp_addr, 31);
    chk("w31_data", disp_data, 5);
    wait_tick(n); chk("period_b", n, 4);
    chk("wrap_rd", rd_addr, 0);
    chk("wrap_hi", wrap, 1);
    step(1); chk("wrap_pulse", wrap, 0);
    chk("tick_pulse", tick, 0);
    step(1); chk("w0_addr", disp_addr, 0);
    chk("w0_data", disp_data, 7);

    // reset in the cycle after a tick, mid-fetch
    wait_tick(n); chk("period_c", n, 4);
    chk("pre_rst_rd", rd_addr, 1);
    reset = 1'b1;
    step(1);
    chk("mr_rd", rd_addr, 0);
    chk("mr_valid", disp_valid, 0);
    chk("mr_data", disp_data, 0);
    chk("mr_addr", disp_addr, 0);
    chk("mr_tick", tick, 0);
    chk("mr_wrap", wrap, 0);
    reset = 1'b0;
    push(0);
    step(1); chk("mr_idle1", disp_valid, 0);
    step(1); chk("mr_idle2", disp_valid, 0);
    step(1); chk("mr_cap", disp_valid, 1);
    chk("mr_cap_data", disp_data, 7);
    step(2);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
